wrf_pkt_arbiter: RTL
====================

WRF_PKT_ARBITER -- requirements
Module: wrf_pkt_arbiter

Interface
REQ-001 SHALL have parameter g_num_ports, default 3: number of WR fabric sink requesters N, legal range 2..8.
REQ-002 SHALL have parameter g_timeout, default 1024: number of idle granted cycles before abort; 0 disables the watchdog.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 clk_sys_i  in  1  system clock; all state SHALL change on its rising edge.
REQ-005 rst_n_i  in  1  asynchronous active-low reset.
REQ-006 snk_cyc_i / snk_stb_i  in  N  per-port cycle and strobe; bit i belongs to port i.
REQ-007 snk_adr_i  in  2N  per-port address; port i uses bits [2i+1:2i].
REQ-008 snk_dat_i  in  16N  per-port data; port i uses bits [16i+15:16i].
REQ-009 snk_sel_i  in  2N  per-port byte select, packed as for snk_adr_i.
REQ-010 snk_ack_o / snk_err_o / snk_stall_o  out  N  per-port ack, err and stall.
REQ-011 src_cyc_o, src_stb_o  out  1;  src_adr_o  out  2;  src_dat_o  out  16;  src_sel_o  out  2: shared fabric source toward the endpoint.
REQ-012 src_ack_i, src_err_i, src_stall_i  in  1  shared source handshake inputs.
REQ-013 grant_o  out  N  one-hot registered grant; all zero when no port is granted.
REQ-014 timeout_o  out  1  one-cycle pulse when the watchdog aborts a packet.

Function
REQ-015 SHALL implement the FSM states IDLE, GRANT and FLUSH, plus a registered grant index g and a last_grant register.
REQ-016 In IDLE: src_cyc_o=0, src_stb_o=0, every snk_stall_o=1, every snk_ack_o=0 and every snk_err_o=0.
REQ-017 In IDLE with any snk_cyc_i high: SHALL select the first requesting port scanning last_grant+1, last_grant+2, ... modulo N; load g; set grant_o; enter GRANT on the next edge.
REQ-018 Arbitration latency SHALL be exactly one cycle: a cyc asserted in IDLE appears on src_cyc_o on the following cycle.
REQ-019 In GRANT, src_cyc/stb/adr/dat/sel SHALL equal the signals of port g combinationally (zero added latency).
REQ-020 In GRANT, snk_stall_o[g]=src_stall_i, snk_ack_o[g]=src_ack_i and snk_err_o[g]=src_err_i.
REQ-021 In GRANT, every non-granted port SHALL see stall=1, ack=0 and err=0.
REQ-022 In GRANT with snk_cyc_i[g] low: SHALL load last_grant<=g, clear grant_o and enter IDLE; packets are never interleaved.
REQ-023 A released port re-requesting immediately SHALL lose to any other requester (round-robin fairness).
REQ-024 src_ack_i and src_err_i arriving while in IDLE or FLUSH SHALL be discarded.
REQ-025 Simultaneous src_ack_i and src_err_i SHALL both be forwarded unchanged to port g.
REQ-026 Watchdog: a counter SHALL clear on entry to GRANT, on src_ack_i, and on an accepted beat (src_stb_o=1 and src_stall_i=0); otherwise it SHALL increment while in GRANT.
REQ-027 When the watchdog count reaches g_timeout (g_timeout nonzero): SHALL enter FLUSH, pulse timeout_o for one cycle and pulse snk_err_o[g]=1 for one cycle.
REQ-028 In FLUSH: src_cyc_o=0 and snk_stall_o[g]=1; SHALL stay in FLUSH until snk_cyc_i[g]=0, then set last_grant<=g and enter IDLE.
REQ-029 The watchdog counter width SHALL be ceil(log2(g_timeout+1)) and SHALL saturate, never wrapping.

Reset
REQ-030 On rst_n_i low the block SHALL asynchronously enter IDLE, with grant_o=0, timeout_o=0, counter=0 and last_grant=N-1, so port 0 wins first.
REQ-031 During reset all outputs SHALL hold their IDLE values, including mid-packet; a requester still holding cyc after reset SHALL be re-arbitrated normally.

Verification
REQ-032 Ports 0 and 2 raise cyc in the same cycle after reset -> grant_o=3'b001; src_cyc_o rises one cycle later; port 2 is granted after port 0 drops cyc.
REQ-033 All 3 ports stream 100 packets each (46..1000 bytes), random src_stall_i -> the sink receives 300 intact, non-interleaved packets, and every port's grants differ by at most 1 at each grant decision.
REQ-034 Port 1 holds cyc with stb=0 and g_timeout=16 -> after 16 granted cycles without progress: timeout_o=1 and snk_err_o[1]=1 for one cycle, src_cyc_o=0; when port 1 drops cyc, port 2 is granted next.
REQ-035 src_ack_i and src_err_i high in the same cycle in GRANT(port 0) -> snk_ack_o=3'b001 and snk_err_o=3'b001; ports 1 and 2 see 0.
REQ-036 rst_n_i low for 2 cycles mid-packet on port 2 -> src_cyc_o=0 and snk_stall_o=3'b111 immediately; after release port 2 still requesting is granted one cycle later.

Source files
------------

// File: rtl/wrf_pkt_arbiter.sv
// Round-robin packet arbiter merging N WR fabric sinks onto one source.
// A grant is held for a whole packet; a watchdog aborts stuck packets.
module wrf_pkt_arbiter #(
  parameter int g_num_ports = 3,
  parameter int g_timeout   = 1024
) (
  input  logic                        clk_sys_i,
  input  logic                        rst_n_i,
  input  logic [g_num_ports-1:0]      snk_cyc_i,
  input  logic [g_num_ports-1:0]      snk_stb_i,
  input  logic [2*g_num_ports-1:0]    snk_adr_i,
  input  logic [16*g_num_ports-1:0]   snk_dat_i,
  input  logic [2*g_num_ports-1:0]    snk_sel_i,
  output logic [g_num_ports-1:0]      snk_ack_o,
  output logic [g_num_ports-1:0]      snk_err_o,
  output logic [g_num_ports-1:0]      snk_stall_o,
  output logic                        src_cyc_o,
  output logic                        src_stb_o,
  output logic [1:0]                  src_adr_o,
  output logic [15:0]                 src_dat_o,
  output logic [1:0]                  src_sel_o,
  input  logic                        src_ack_i,
  input  logic                        src_err_i,
  input  logic                        src_stall_i,
  output logic [g_num_ports-1:0]      grant_o,
  output logic                        timeout_o
);
  localparam int N  = g_num_ports;
  localparam int IW = $clog2(N);
  localparam int CW = (g_timeout > 0) ? $clog2(g_timeout + 1) : 1;
  localparam logic [CW-1:0] TMO   = CW'(g_timeout);
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [IW-1:0] LAST0 = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FLUSH
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   g, g_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [IW-1:0]   pick;
  logic            found;
  logic [IW:0]     idx;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [N-1:0]    grant_nxt;
  logic            tmo_nxt;
  logic            busy;

  // Rotating priority: scan last+1, last+2, ... wrapping at N
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, last} + (IW+1)'(k);
      if (idx >= (IW+1)'(N))
        idx = idx - (IW+1)'(N);
      if (!found && snk_cyc_i[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  assign busy      = (state == GRANT);
  assign src_cyc_o = busy & snk_cyc_i[g];
  assign src_stb_o = busy & snk_stb_i[g];
  assign src_adr_o = snk_adr_i[2*g +: 2];
  assign src_sel_o = snk_sel_i[2*g +: 2];
  assign src_dat_o = snk_dat_i[16*g +: 16];

  always_comb begin
    snk_stall_o = '1;
    snk_ack_o   = '0;
    snk_err_o   = '0;
    if (state == GRANT) begin
      snk_stall_o[g] = src_stall_i;
      snk_ack_o[g]   = src_ack_i;
      snk_err_o[g]   = src_err_i;
    end else if (state == FLUSH) begin
      snk_err_o[g]   = timeout_o;
    end
  end

  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    grant_nxt = grant_o;
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          g_nxt        = pick;
          grant_nxt    = '0;
          grant_nxt[pick] = 1'b1;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (!snk_cyc_i[g]) begin
          last_nxt  = g;
          grant_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (src_ack_i || (src_stb_o && !src_stall_i)) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (g_timeout != 0 && cnt_inc == TMO) begin
            state_nxt = FLUSH;
            tmo_nxt   = 1'b1;
          end
        end
      end
      FLUSH: begin
        cnt_nxt = '0;
        if (!snk_cyc_i[g]) begin
          last_nxt  = g;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      g         <= '0;
      last      <= LAST0;
      grant_o   <= '0;
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      last      <= last_nxt;
      grant_o   <= grant_nxt;
      cnt       <= cnt_nxt;
      timeout_o <= tmo_nxt;
    end
  end

endmodule
